four_bit_minmax_tracker: RTL
============================

FOUR_BIT_MINMAX_TRACKER -- requirements
Module: four_bit_minmax_tracker

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  async active-low reset.
REQ-004 in_valid  input  1  sample offered.
REQ-005 in_ready  output  1  tracker accepts sample this cycle.
REQ-006 in_data  input  4  unsigned sample.
REQ-007 in_last  input  1  sample closes current frame.
REQ-008 cmp_a  output  4  registered held sample, to external 4-bit comparators (A operand).
REQ-009 cmp_max  output  4  running max register (B operand, comparator 0).
REQ-010 cmp_min  output  4  running min register (B operand, comparator 1).
REQ-011 max_lt, max_gt, max_eq  input  1 each  comparator 0 flags (cmp_a vs cmp_max).
REQ-012 min_lt, min_gt, min_eq  input  1 each  comparator 1 flags (cmp_a vs cmp_min).
REQ-013 out_valid  output  1  frame result available.
REQ-014 out_ready  input  1  consumer takes result.
REQ-015 out_max, out_min  output  4 each  frame max/min.
REQ-016 out_len  output  5  samples in frame, saturating at 31.
REQ-017 out_max_cnt  output  5  samples equal to final max, saturating at 31.
REQ-018 cmp_err  output  1  sticky comparator-flag fault (see Configuration).

Function
REQ-019 States: IDLE (no frame open), EVAL (apply flags to held sample), WAIT (frame open, awaiting sample), DONE (result held).
REQ-020 in_ready SHALL be 1 in IDLE and WAIT only; accept = in_valid & in_ready.
REQ-021 On accept: cmp_a <= in_data, last flag latched, state -> EVAL; throughput one sample per 2 cycles.
REQ-022 EVAL, first sample of frame: max <= min <= cmp_a, max_cnt <= 1, len <= 1; flags ignored.
REQ-023 EVAL, later samples: max_gt -> max <= cmp_a, max_cnt <= 1; max_eq -> max_cnt +1 saturating; min_lt -> min <= cmp_a; len +1 saturating.
REQ-024 EVAL exit: latched last -> DONE with out_* loaded from updated registers and out_valid <= 1; else -> WAIT.
REQ-025 DONE: out_valid and out_* SHALL hold stable until out_valid & out_ready; on that edge -> IDLE, out_valid <= 0.
REQ-026 out_ready high on the same edge out_valid first rises is not a transfer; transfer requires out_valid already 1.
REQ-027 in_valid during EVAL or DONE SHALL be stalled (not dropped); in_data must be held by source.
REQ-028 in_last on the first sample SHALL yield len=1, max=min=sample, max_cnt=1.
REQ-029 Saturation: len and max_cnt SHALL stick at 31, never wrap.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, in_ready 0 while low, out_valid 0, cmp_a/cmp_max/cmp_min/out_* 0, counters 0, cmp_err 0.
REQ-031 Reset mid-frame or in DONE SHALL discard the partial/pending result; first cycle after release in_ready=1.

Configuration
REQ-032 Macro MINMAX_FLAG_CHECK_EN: when defined, in each non-first EVAL cycle, if {max_lt,max_gt,max_eq} or {min_lt,min_gt,min_eq} is not exactly one-hot, cmp_err SHALL set and stay 1 until reset; update proceeds per REQ-023.
REQ-033 Without MINMAX_FLAG_CHECK_EN, cmp_err SHALL be constant 0 and no check logic built.

Verification (bench drives flags from a behavioural 4-bit compare model)
REQ-034 Frame 5,9,2,9(last), out_ready=1 -> out_max=9, out_min=2, out_len=4, out_max_cnt=2, one out_valid pulse.
REQ-035 Single sample 7 with in_last -> out_max=out_min=7, out_len=1, out_max_cnt=1; in_ready low in EVAL and DONE.
REQ-036 40 samples of 15, last on 40th -> out_len=31, out_max_cnt=31, out_min=15.
REQ-037 Frame ends with out_ready=0 for 5 cycles while in_valid=1 -> out_* stable, in_ready=0, next frame's first sample accepted only after transfer.
REQ-038 rst_n pulsed low after 3 samples of a frame -> all outputs 0 immediately; new frame 4(last) gives max=min=4, len=1.
REQ-039 With MINMAX_FLAG_CHECK_EN, second sample with max_lt=max_gt=1 forced -> cmp_err=1 after that EVAL edge, held through next frame; without macro cmp_err=0.

Source files
------------

// File: rtl/four_bit_minmax_tracker.sv
// four_bit_minmax_tracker: per-frame running max/min tracker that borrows two
// external 4-bit magnitude comparators.
// Each accepted sample is held in cmp_a for one EVAL cycle. During that cycle
// the comparator flags decide how the running max, min and counters update.
// A frame result is held on out_* until the consumer takes it.
// Optional build macro: MINMAX_FLAG_CHECK_EN adds a sticky check (cmp_err) that
// the comparator flags are one-hot.
//
// Handshake: a transfer happens on a rising clk edge where valid & ready are
// both 1. The source keeps data stable while valid is high and ready is low.
// Valid does not depend combinationally on ready. in_ready depends only on the
// state and rst_n. out_valid is registered and falls only after a transfer.
module four_bit_minmax_tracker (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  input  logic       in_last,
  output logic [3:0] cmp_a,
  output logic [3:0] cmp_max,
  output logic [3:0] cmp_min,
  input  logic       max_lt,
  input  logic       max_gt,
  input  logic       max_eq,
  input  logic       min_lt,
  input  logic       min_gt,
  input  logic       min_eq,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_max,
  output logic [3:0] out_min,
  output logic [4:0] out_len,
  output logic [4:0] out_max_cnt,
  output logic       cmp_err,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic       last_q, last_d;
  logic       first_q, first_d;
  logic [3:0] max_q, max_d;
  logic [3:0] min_q, min_d;
  logic [4:0] len_q, len_d;
  logic [4:0] cnt_q, cnt_d;
  logic [3:0] omax_q, omax_d;
  logic [3:0] omin_q, omin_d;
  logic [4:0] olen_q, olen_d;
  logic [4:0] ocnt_q, ocnt_d;
  logic       ov_q, ov_d;
  logic       accept;

  // Samples are taken only while no frame sample is being evaluated and no
  // result is pending. The gate with rst_n keeps ready low during reset.
  assign in_ready = rst_n & ((state_q == S_IDLE) | (state_q == S_WAIT));
  assign accept   = in_valid & in_ready;

  assign cmp_a       = a_q;
  assign cmp_max     = max_q;
  assign cmp_min     = min_q;
  assign out_valid   = ov_q;
  assign out_max     = omax_q;
  assign out_min     = omin_q;
  assign out_len     = olen_q;
  assign out_max_cnt = ocnt_q;
  assign dbg_state   = state_q;

  // Next-state and datapath update for the sample/frame FSM.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    last_d  = last_q;
    first_d = first_q;
    max_d   = max_q;
    min_d   = min_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    omax_d  = omax_q;
    omin_d  = omin_q;
    olen_d  = olen_q;
    ocnt_d  = ocnt_q;
    ov_d    = ov_q;
    case (state_q)
      S_IDLE, S_WAIT: begin
        if (accept) begin
          a_d     = in_data;
          last_d  = in_last;
          // A sample taken from IDLE opens a new frame.
          first_d = (state_q == S_IDLE);
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (first_q) begin
          // The first sample seeds the registers, so the flags are not used.
          max_d = a_q;
          min_d = a_q;
          cnt_d = 5'd1;
          len_d = 5'd1;
        end else begin
          // A new max resets the tie count. An equal sample extends it.
          if (max_gt) begin
            max_d = a_q;
            cnt_d = 5'd1;
          end else if (max_eq) begin
            cnt_d = (cnt_q == 5'd31) ? 5'd31 : cnt_q + 5'd1;
          end
          if (min_lt) begin
            min_d = a_q;
          end
          len_d = (len_q == 5'd31) ? 5'd31 : len_q + 5'd1;
        end
        if (last_q) begin
          omax_d  = max_d;
          omin_d  = min_d;
          olen_d  = len_d;
          ocnt_d  = cnt_d;
          ov_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        // A transfer needs out_valid to be high already before this edge.
        if (ov_q && out_ready) begin
          ov_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers. Reset discards any open or pending frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= 4'd0;
      last_q  <= 1'b0;
      first_q <= 1'b0;
      max_q   <= 4'd0;
      min_q   <= 4'd0;
      len_q   <= 5'd0;
      cnt_q   <= 5'd0;
      omax_q  <= 4'd0;
      omin_q  <= 4'd0;
      olen_q  <= 5'd0;
      ocnt_q  <= 5'd0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      last_q  <= last_d;
      first_q <= first_d;
      max_q   <= max_d;
      min_q   <= min_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      omax_q  <= omax_d;
      omin_q  <= omin_d;
      olen_q  <= olen_d;
      ocnt_q  <= ocnt_d;
      ov_q    <= ov_d;
    end
  end

`ifdef MINMAX_FLAG_CHECK_EN
  logic err_q, err_d;
  logic flags_bad;

  // Only non-first EVAL cycles use the flags, so only those cycles are checked.
  assign flags_bad = (state_q == S_EVAL) && !first_q &&
                     (!$onehot({max_lt, max_gt, max_eq}) ||
                      !$onehot({min_lt, min_gt, min_eq}));

  // Once set, the error stays set until reset.
  always_comb begin
    err_d = err_q;
    if (flags_bad) begin
      err_d = 1'b1;
    end
  end

  // Register for the sticky comparator fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign cmp_err = err_q;
`else
  // These flags are read only by the optional check.
  logic unused_flags;
  assign unused_flags = ^{max_lt, min_gt, min_eq};
  assign cmp_err      = 1'b0;
`endif

endmodule
